// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 32;

    typedef logic [SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready drain side.
// Optional per-slot drain counter under DEMUX_COUNT_EN.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             full,
    output logic [WIDTH-1:0] data
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic             full_r;
    logic             full_next_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_next_s;

    // Load wins over drain so a same-cycle refill keeps the slot full.
    always_comb begin
        full_next_s = full_r;
        data_next_s = data_r;
        if (load) begin
            full_next_s = 1'b1;
            data_next_s = load_data;
        end else if (full_r && drain_ready) begin
            full_next_s = 1'b0;
        end else begin
            full_next_s = full_r;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else begin
            full_r <= full_next_s;
            data_r <= data_next_s;
        end
    end

    assign full = full_r;
    assign data = data_r;

`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0] cnt_r;

    // Completed-transfer counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (full_r && drain_ready) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
`endif

endmodule

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 data distributor with per-channel holding slots.
// Define DEMUX_COUNT_EN to add per-channel drain counters (out_cnt_k).
module demux_1x4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W
`ifdef DEMUX_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  ch_sel_t           in_sel,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data_0,
    output logic [WIDTH-1:0]  out_data_1,
    output logic [WIDTH-1:0]  out_data_2,
    output logic [WIDTH-1:0]  out_data_3
`ifdef DEMUX_COUNT_EN
    ,
    output logic [CNT_W-1:0]  out_cnt_0,
    output logic [CNT_W-1:0]  out_cnt_1,
    output logic [CNT_W-1:0]  out_cnt_2,
    output logic [CNT_W-1:0]  out_cnt_3
`endif
);

    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] load_s;
    logic              accept_s;
    logic [WIDTH-1:0]  data_s [NUM_CH];
`ifdef DEMUX_COUNT_EN
    logic [CNT_W-1:0]  cnt_s  [NUM_CH];
`endif

    // Ready depends only on the selected slot, so it follows in_sel even when idle.
    assign in_ready = !rst && (!full_s[in_sel] || out_ready[in_sel]);
    assign accept_s = in_valid && in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign load_s[k] = accept_s && (in_sel == ch_sel_t'(k));

        demux_slot #(
            .WIDTH      (WIDTH)
`ifdef DEMUX_COUNT_EN
            ,
            .CNT_W      (CNT_W)
`endif
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load_s[k]),
            .load_data  (in_data),
            .drain_ready(out_ready[k]),
            .full       (full_s[k]),
            .data       (data_s[k])
`ifdef DEMUX_COUNT_EN
            ,
            .cnt        (cnt_s[k])
`endif
        );
    end

    assign out_valid  = full_s;
    assign out_data_0 = data_s[0];
    assign out_data_1 = data_s[1];
    assign out_data_2 = data_s[2];
    assign out_data_3 = data_s[3];
`ifdef DEMUX_COUNT_EN
    assign out_cnt_0  = cnt_s[0];
    assign out_cnt_1  = cnt_s[1];
    assign out_cnt_2  = cnt_s[2];
    assign out_cnt_3  = cnt_s[3];
`endif

endmodule

// File: tb/tb_demux_1x4_reg.sv
// Scoreboard bench for demux_1x4_reg: directed scenarios plus random traffic.
module tb_demux_1x4_reg;

    localparam int W  = 32;
`ifdef DEMUX_COUNT_EN
    localparam int CW = 4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [W-1:0]  out_data_0, out_data_1, out_data_2, out_data_3;
`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] out_cnt_0, out_cnt_1, out_cnt_2, out_cnt_3;
`endif

    demux_1x4_reg #(
        .WIDTH(W)
`ifdef DEMUX_COUNT_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data_0(out_data_0),
        .out_data_1(out_data_1),
        .out_data_2(out_data_2),
        .out_data_3(out_data_3)
`ifdef DEMUX_COUNT_EN
        ,
        .out_cnt_0 (out_cnt_0),
        .out_cnt_1 (out_cnt_1),
        .out_cnt_2 (out_cnt_2),
        .out_cnt_3 (out_cnt_3)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: words accepted per channel, oldest first.
    logic [W-1:0] sbq [4][$];

    // Reference model: slot occupancy, held word and drain count per channel.
    bit           occ  [4];
    logic [W-1:0] held [4];
    int unsigned  mcnt [4];

    function automatic logic [W-1:0] dout(int k);
        case (k)
            0:       return out_data_0;
            1:       return out_data_1;
            2:       return out_data_2;
            default: return out_data_3;
        endcase
    endfunction

`ifdef DEMUX_COUNT_EN
    function automatic logic [CW-1:0] dcnt(int k);
        case (k)
            0:       return out_cnt_0;
            1:       return out_cnt_1;
            2:       return out_cnt_2;
            default: return out_cnt_3;
        endcase
    endfunction
`endif

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every drain handshake must deliver the oldest word queued for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL drain_unexpected ch=%0d actual=%0h required=none", k, dout(k));
                    end else begin
                        check($sformatf("drain_data_ch%0d", k), 64'(dout(k)), 64'(sbq[k].pop_front()));
                    end
                end
            end
        end
    end

    // One clock of stimulus; compares handshake/holding state against the model.
    task automatic step(logic v, logic [1:0] sel, logic [W-1:0] data, logic [3:0] ordy);
        logic [3:0] exp_valid;
        logic       exp_rdy;
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
        @(negedge clk);
        exp_rdy = !occ[sel] || ordy[sel];
        for (int k = 0; k < 4; k++) exp_valid[k] = occ[k];
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        for (int k = 0; k < 4; k++) begin
            if (occ[k]) check($sformatf("held_data_ch%0d", k), 64'(dout(k)), 64'(held[k]));
`ifdef DEMUX_COUNT_EN
            check($sformatf("cnt_ch%0d", k), 64'(dcnt(k)), 64'(mcnt[k] % (1 << CW)));
`endif
        end
        for (int k = 0; k < 4; k++) begin
            if (occ[k] && ordy[k]) begin
                occ[k] = 1'b0;
                mcnt[k]++;
            end
        end
        if (v && exp_rdy) begin
            occ[sel]  = 1'b1;
            held[sel] = data;
            sbq[sel].push_back(data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) check($sformatf("%s_data_ch%0d", tag, k), 64'(dout(k)), 64'd0);
`ifdef DEMUX_COUNT_EN
        for (int k = 0; k < 4; k++) check($sformatf("%s_cnt_ch%0d", tag, k), 64'(dcnt(k)), 64'd0);
`endif
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            occ[k]  = 1'b0;
            held[k] = '0;
            mcnt[k] = 0;
            sbq[k].delete();
        end
    endtask

    initial begin
        int sbleft;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        model_clear();
        #2;
        check_reset_outputs("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset release: ready, nothing valid.
        step(1'b0, 2'd0, 32'h0, 4'b0000);

        // Single route to channel 2, held for 5 cycles, then drained.
        step(1'b1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
        for (int i = 0; i < 5; i++) step(1'b0, 2'd2, 32'h0, 4'b0000);
        step(1'b0, 2'd0, 32'h0, 4'b0100);

        // Backpressure on channel 1, redirect to channel 3.
        step(1'b1, 2'd1, 32'hAAAA_0001, 4'b0000);
        step(1'b1, 2'd1, 32'hAAAA_0002, 4'b0000);
        step(1'b1, 2'd3, 32'hAAAA_0003, 4'b0000);
        step(1'b0, 2'd0, 32'h0, 4'b1111);

        // Pass-through refill on channel 0.
        step(1'b1, 2'd0, 32'h1, 4'b0000);
        step(1'b1, 2'd0, 32'h2, 4'b0001);
        step(1'b0, 2'd0, 32'h0, 4'b0000);
        step(1'b0, 2'd0, 32'h0, 4'b0001);

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i % 4), $urandom, 4'b1111);
        step(1'b0, 2'd0, 32'h0, 4'b1111);

        // Asynchronous reset mid-transfer.
        step(1'b1, 2'd1, 32'h1111_1111, 4'b0000);
        step(1'b1, 2'd2, 32'h2222_2222, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 2'd1, 32'h0, 4'b0000);

        // 17 drains on channel 0 (counter wrap when counters are built).
        for (int i = 0; i < 17; i++) step(1'b1, 2'd0, $urandom, 4'b0001);
        step(1'b0, 2'd0, 32'h0, 4'b0001);
        step(1'b0, 2'd0, 32'h0, 4'b0000);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));

        step(1'b0, 2'd0, 32'h0, 4'b1111);
        step(1'b0, 2'd0, 32'h0, 4'b1111);
        sbleft = 0;
        for (int k = 0; k < 4; k++) sbleft += sbq[k].size();
        check("scoreboard_empty", 64'(sbleft), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
